tppe_stream: RTL and testbench

- Streaming successor to the single-tile timestep-parallel PE for the SNN-ANN hybrid array.
- Accepts bitmask-compressed tiles over a valid/ready handshake and intersects the spike-fiber A mask with the ANN-fiber B mask.
- For each match, reads the compressed A spike word (T bits) from an external 1-cycle-latency SRAM port and accumulates B into T per-timestep sums, using the pseudo-accumulator/correction scheme.
- Accumulates across multiple tiles until a tile flagged last, then emits T results over a second valid/ready handshake.

---
 rtl/tppe_pkg.sv | 57 +++++
 rtl/tppe_match_sel.sv | 25 ++
 rtl/tppe_stream.sv | 179 +++++++++++++++++
 tb/tb_tppe_stream.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tppe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tppe_pkg: shared types and bit-scan helpers for the streaming TPPE         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package tppe_pkg;

  localparam int MAX_W = 64;
  localparam int IDX_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic logic [IDX_W-1:0] lowest_set_bit(input logic [MAX_W-1:0] mask);
    logic [IDX_W-1:0] idx;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (!found && mask[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Number of set bits strictly below position p.
  function automatic logic [IDX_W-1:0] masked_popcount(input logic [MAX_W-1:0] mask,
                                                       input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (IDX_W'(i) < p) cnt = cnt + IDX_W'(mask[i]);
    end
    return cnt;
  endfunction

  function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] v, input int q,
                                              input logic sgn);
    logic [MAX_W-1:0] r;
    logic             msb;
    msb = 1'b0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i == q - 1) msb = v[i];
    end
    for (int i = 0; i < MAX_W; i++) begin
      r[i] = (i < q) ? v[i] : (sgn & msb);
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tppe_match_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tppe_match_sel: picks the lowest pending match and its rank among A        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tppe_match_sel
  import tppe_pkg::*;
#(
  parameter int N   = 16,
  parameter int P_W = 4,
  parameter int R_W = 5
) (
  input  logic [N-1:0]   match_mask,
  input  logic [N-1:0]   bitmask_a,
  output logic [P_W-1:0] p,
  output logic [R_W-1:0] rank,
  output logic           any
);

  assign any  = |match_mask;
  assign p    = P_W'(lowest_set_bit(MAX_W'(match_mask)));
  assign rank = R_W'(masked_popcount(MAX_W'(bitmask_a), lowest_set_bit(MAX_W'(match_mask))));

endmodule
`default_nettype wire

// File: rtl/tppe_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tppe_stream: streaming timestep-parallel PE with pseudo/correction accum   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tppe_stream
  import tppe_pkg::*;
#(
  parameter int T        = 4,
  parameter int Q        = 8,
  parameter int N        = 16,
  parameter int SIGNED_B = 0,
  parameter int ACC_W    = 16,
  parameter int AW       = 10,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_bitmask_a,
  input  logic [N-1:0]       in_bitmask_b,
  input  logic [N*Q-1:0]     in_fiber_b,
  input  logic [AW-1:0]      in_a_base,
  input  logic               in_last,
  output logic               a_rd_en,
  output logic [AW-1:0]      a_rd_addr,
  input  logic [T-1:0]       a_rd_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [T*ACC_W-1:0] out_result,
  output logic [CNT_W-1:0]   out_match_cnt
);

  localparam int P_W = (N > 1) ? $clog2(N) : 1;
  localparam int R_W = $clog2(N + 1);

  state_t r_state, w_state_nxt;

  logic [N-1:0]       r_mask;
  logic [N-1:0]       r_bmask_a;
  logic [N*Q-1:0]     r_fiber_b;
  logic [AW-1:0]      r_base;
  logic               r_last;
  logic               r_pend;
  logic [ACC_W-1:0]   r_bpend;
  logic [ACC_W-1:0]   r_pseudo;
  logic [ACC_W-1:0]   r_corr [T];
  logic [CNT_W-1:0]   r_cnt;
  logic [T*ACC_W-1:0] r_result;

  logic [P_W-1:0]     w_p;
  logic [R_W-1:0]     w_rank;
  logic               w_any;
  logic [Q-1:0]       w_bsel;
  logic [ACC_W-1:0]   w_bext;
  logic [ACC_W-1:0]   w_pseudo_nxt;
  logic [ACC_W-1:0]   w_corr_nxt [T];
  logic [T*ACC_W-1:0] w_result_nxt;
  logic               w_out_done;
  logic               w_scan_exit;

  tppe_match_sel #(
    .N   (N),
    .P_W (P_W),
    .R_W (R_W)
  ) u_match_sel (
    .match_mask (r_mask),
    .bitmask_a  (r_bmask_a),
    .p          (w_p),
    .rank       (w_rank),
    .any        (w_any)
  );

  assign w_bsel      = r_fiber_b[w_p*Q +: Q];
  assign w_bext      = ACC_W'(extend(MAX_W'(w_bsel), Q, SIGNED_B != 0));
  assign w_out_done  = (r_state == OUT) && out_ready;
  assign w_scan_exit = (r_state == SCAN) && !w_any;

  // The spike word returns one cycle after the read, aligned with r_pend.
  always_comb begin
    w_pseudo_nxt = r_pseudo;
    for (int t = 0; t < T; t++) w_corr_nxt[t] = r_corr[t];
    if (r_pend) begin
      w_pseudo_nxt = r_pseudo + r_bpend;
      for (int t = 0; t < T; t++) begin
        if (!a_rd_data[t]) w_corr_nxt[t] = r_corr[t] + r_bpend;
      end
    end
  end

  for (genvar t = 0; t < T; t++) begin : g_result
    assign w_result_nxt[t*ACC_W +: ACC_W] = w_pseudo_nxt - w_corr_nxt[t];
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    a_rd_en     = 1'b0;
    a_rd_addr   = '0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = SCAN;
      end
      SCAN: begin
        if (w_any) begin
          a_rd_en   = 1'b1;
          a_rd_addr = r_base + AW'(w_rank);
        end else begin
          w_state_nxt = r_last ? OUT : IDLE;
        end
      end
      OUT: begin
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask    <= '0;
      r_bmask_a <= '0;
      r_fiber_b <= '0;
      r_base    <= '0;
      r_last    <= 1'b0;
      r_pend    <= 1'b0;
      r_bpend   <= '0;
    end else begin
      if (r_state == IDLE && in_valid) begin
        r_mask    <= in_bitmask_a & in_bitmask_b;
        r_bmask_a <= in_bitmask_a;
        r_fiber_b <= in_fiber_b;
        r_base    <= in_a_base;
        r_last    <= in_last;
      end
      if (r_state == SCAN && w_any) begin
        r_bpend <= w_bext;
        r_pend  <= 1'b1;
        r_mask  <= r_mask & ~(N'(1) << w_p);
      end else begin
        r_pend  <= 1'b0;
      end
    end
  end

  // Accumulators persist across non-last tiles; only the output handshake clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pseudo <= '0;
      for (int t = 0; t < T; t++) r_corr[t] <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (w_out_done) begin
        r_pseudo <= '0;
        for (int t = 0; t < T; t++) r_corr[t] <= '0;
        r_cnt    <= '0;
      end else begin
        r_pseudo <= w_pseudo_nxt;
        for (int t = 0; t < T; t++) r_corr[t] <= w_corr_nxt[t];
        if (r_pend && r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_scan_exit && r_last) r_result <= w_result_nxt;
    end
  end

  assign out_valid     = (r_state == OUT);
  assign out_result    = r_result;
  assign out_match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tppe_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tppe_stream: directed table-driven bench for tppe_stream                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_tppe_stream;

  localparam int T = 4, Q = 8, N = 16, AW = 10, CNT_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, in_last, out_ready;
  logic [N-1:0]   in_bitmask_a, in_bitmask_b;
  logic [N*Q-1:0] in_fiber_b;
  logic [AW-1:0]  in_a_base;
  logic [3:0]     sram [1024];

  logic in_ready0, in_ready1, in_ready2;
  logic rd_en0, rd_en1, rd_en2;
  logic [AW-1:0] addr0, addr1, addr2;
  logic [3:0] rdat0, rdat1, rdat2;
  logic ov0, ov1, ov2;
  logic [63:0] res0, res1;
  logic [31:0] res2;
  logic [7:0] cnt0, cnt1, cnt2;

  tppe_stream u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_bitmask_a(in_bitmask_a), .in_bitmask_b(in_bitmask_b), .in_fiber_b(in_fiber_b),
    .in_a_base(in_a_base), .in_last(in_last), .a_rd_en(rd_en0), .a_rd_addr(addr0),
    .a_rd_data(rdat0), .out_valid(ov0), .out_ready(out_ready), .out_result(res0),
    .out_match_cnt(cnt0));

  tppe_stream #(.SIGNED_B(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(in_ready1), .in_bitmask_a(in_bitmask_a), .in_bitmask_b(in_bitmask_b),
    .in_fiber_b(in_fiber_b), .in_a_base(in_a_base), .in_last(in_last), .a_rd_en(rd_en1),
    .a_rd_addr(addr1), .a_rd_data(rdat1), .out_valid(ov1), .out_ready(out_ready),
    .out_result(res1), .out_match_cnt(cnt1));

  tppe_stream #(.ACC_W(8)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in_ready(in_ready2), .in_bitmask_a(in_bitmask_a), .in_bitmask_b(in_bitmask_b),
    .in_fiber_b(in_fiber_b), .in_a_base(in_a_base), .in_last(in_last), .a_rd_en(rd_en2),
    .a_rd_addr(addr2), .a_rd_data(rdat2), .out_valid(ov2), .out_ready(out_ready),
    .out_result(res2), .out_match_cnt(cnt2));

  // 1-cycle-latency SRAM model per instance
  always @(posedge clk) begin
    rdat0 <= sram[addr0];
    rdat1 <= sram[addr1];
    rdat2 <= sram[addr2];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] rd_q[$];
  int            rd_cyc[$];
  always @(negedge clk) begin
    if (rd_en0) begin
      rd_q.push_back(addr0);
      rd_cyc.push_back(cyc);
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*Q-1:0] fbv(input int i0, input int v0, input int i1, input int v1);
    logic [N*Q-1:0] f;
    f = '0;
    f[i0*Q +: Q] = Q'(v0);
    f[i1*Q +: Q] = Q'(v1);
    return f;
  endfunction

  // Hands one tile over and waits for out_valid (last) or in_ready (not last).
  task automatic send_tile(input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [N*Q-1:0] fb, input logic [AW-1:0] base,
                           input logic last, input int m, input string tag);
    int  edges;
    bit  seen;
    rd_q.delete();
    rd_cyc.delete();
    @(negedge clk);
    check({tag, " in_ready before"}, 64'(in_ready0), 64'd1);
    in_valid     = 1'b1;
    in_bitmask_a = a;
    in_bitmask_b = b;
    in_fiber_b   = fb;
    in_a_base    = base;
    in_last      = last;
    @(posedge clk);
    #1 in_valid = 1'b0;
    edges = 0;
    seen  = 1'b0;
    while (edges < 40 && !seen) begin
      if (last ? ov0 : in_ready0) seen = 1'b1;
      else begin
        @(posedge clk);
        #1 edges++;
      end
    end
    check({tag, " latency"}, 64'(edges + 1), 64'(m + 2));
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("drain out_valid", 64'(ov0), 64'd0);
  endtask

  typedef struct {
    logic [N-1:0]    a;
    logic [N-1:0]    b;
    logic [N*Q-1:0]  fb;
    logic [AW-1:0]   base;
    int              m;
    logic [2*AW-1:0] ea;
    logic [63:0]     exp;
    logic [7:0]      cnt;
  } vec_t;

  vec_t tbl[3];

  initial begin
    logic [63:0] held;

    tbl[0] = '{a: 16'h000F, b: 16'h0005, fb: fbv(0, 3, 2, 7), base: 10'd100, m: 2,
               ea: {10'd102, 10'd100}, exp: {16'd3, 16'd10, 16'd3, 16'd10}, cnt: 8'd2};
    tbl[1] = '{a: 16'h00F0, b: 16'h000F, fb: fbv(0, 1, 4, 2), base: 10'd50, m: 0,
               ea: '0, exp: 64'd0, cnt: 8'd0};
    tbl[2] = '{a: 16'hFFFF, b: 16'h8001, fb: fbv(0, 1, 15, 200), base: 10'd1020, m: 2,
               ea: {10'd11, 10'd1020}, exp: {16'd1, 16'd200, 16'd201, 16'd0}, cnt: 8'd2};

    for (int i = 0; i < 1024; i++) sram[i] = 4'b0000;
    sram[100] = 4'b1111; sram[102] = 4'b0101;
    sram[1020] = 4'b1010; sram[11] = 4'b0110;
    sram[200] = 4'b0011; sram[210] = 4'b1100;
    sram[400] = 4'b1001;
    sram[300] = 4'b1111; sram[301] = 4'b1111;

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_bitmask_a = '0; in_bitmask_b = '0; in_fiber_b = '0; in_a_base = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 64'(in_ready0), 64'd1);
    check("reset a_rd_en", 64'(rd_en0), 64'd0);
    check("reset a_rd_addr", 64'(addr0), 64'd0);
    check("reset out_valid", 64'(ov0), 64'd0);
    check("reset out_result", res0, 64'd0);
    check("reset match_cnt", 64'(cnt0), 64'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      send_tile(tbl[i].a, tbl[i].b, tbl[i].fb, tbl[i].base, 1'b1, tbl[i].m, "vec");
      check("vec result", res0, tbl[i].exp);
      check("vec match_cnt", 64'(cnt0), 64'(tbl[i].cnt));
      check("vec read count", 64'(rd_q.size()), 64'(tbl[i].m));
      for (int j = 0; j < tbl[i].m && j < rd_q.size(); j++)
        check("vec read addr", 64'(rd_q[j]), 64'(tbl[i].ea[j*AW +: AW]));
      if (rd_cyc.size() == 2) check("vec reads back-to-back", 64'(rd_cyc[1] - rd_cyc[0]), 64'd1);
      drain();
    end

    // Two-tile group
    send_tile(16'h0001, 16'h0001, fbv(0, 5, 1, 0), 10'd200, 1'b0, 1, "tile1");
    check("between tiles out_valid", 64'(ov0), 64'd0);
    send_tile(16'h0002, 16'h0002, fbv(1, 9, 0, 0), 10'd210, 1'b1, 1, "tile2");
    check("group result", res0, {16'd9, 16'd9, 16'd5, 16'd5});
    check("group match_cnt", 64'(cnt0), 64'd2);
    drain();

    // Sign extension: B = -2
    send_tile(16'h0004, 16'h0004, fbv(2, 8'hFE, 0, 0), 10'd400, 1'b1, 1, "signed");
    check("unsigned FE result", res0, {16'h00FE, 16'd0, 16'd0, 16'h00FE});
    check("signed FE result", res1, {16'hFFFE, 16'd0, 16'd0, 16'hFFFE});
    drain();

    // 200 + 100 = 300 wraps to 44 at 8 bits (and -56 + 100 = 44 signed)
    send_tile(16'h0003, 16'h0003, fbv(0, 200, 1, 100), 10'd300, 1'b1, 2, "wrap");
    check("wrap acc8 result", 64'(res2), 64'h2C2C2C2C);
    check("wrap acc16 result", res0, {4{16'd300}});
    check("wrap signed result", res1, {4{16'd44}});
    check("wrap acc8 match_cnt", 64'(cnt2), 64'd2);
    drain();

    // Backpressure on the result port
    send_tile(tbl[0].a, tbl[0].b, tbl[0].fb, tbl[0].base, 1'b1, 2, "hold");
    held = res0;
    @(negedge clk);
    in_valid = 1'b1; in_bitmask_a = 16'h0001; in_bitmask_b = 16'h0001;
    in_fiber_b = fbv(0, 77, 1, 0); in_a_base = 10'd0; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("hold result stable", res0, held);
      check("hold in_ready", 64'(in_ready0), 64'd0);
      check("hold out_valid", 64'(ov0), 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    send_tile(16'h0002, 16'h0002, fbv(1, 9, 0, 0), 10'd210, 1'b1, 1, "after hold");
    check("after hold result", res0, {16'd9, 16'd9, 16'd0, 16'd0});
    check("after hold match_cnt", 64'(cnt0), 64'd1);
    drain();

    // Asynchronous reset in the middle of a scan
    @(negedge clk);
    in_valid = 1'b1; in_bitmask_a = tbl[0].a; in_bitmask_b = tbl[0].b;
    in_fiber_b = tbl[0].fb; in_a_base = tbl[0].base; in_last = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid-scan a_rd_en", 64'(rd_en0), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort a_rd_en", 64'(rd_en0), 64'd0);
    check("abort out_valid", 64'(ov0), 64'd0);
    check("abort in_ready", 64'(in_ready0), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    send_tile(16'h0001, 16'h0001, fbv(0, 5, 1, 0), 10'd200, 1'b1, 1, "post reset");
    check("post reset result", res0, {16'd0, 16'd0, 16'd5, 16'd5});
    check("post reset match_cnt", 64'(cnt0), 64'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
